bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Central controller for the serial system bus. Arbitrates two masters with round-robin priority and decodes the serially shifted slave-select bits that lead each address.
- Drives slave select to the bus mux, holds ownership until the slave signals completion, supports slave-initiated split transactions, and aborts hung transfers with a timeout.
- Sits between the master ports and the slave ports (each slave port fronts a 4K x 8 BRAM).

Parameters:
- NUM_SLAVES, 3: number of attached slaves; valid select values are 0 to NUM_SLAVES-1.
- SEL_BITS, 2: slave-select bits that precede the 12-bit local address on rx_addr, sent MSB first.
- TIMEOUT, 255: maximum CONNECT cycles without tx_done before abort.

Ports:
- clk, input, 1: bus clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- m1_req, input, 1: master 1 requests the bus; held high for the whole transaction.
- m2_req, input, 1: master 2 request.
- m1_grant, output, 1: master 1 owns the bus.
- m2_grant, output, 1: master 2 owns the bus.
- master_valid, input, 1: owning master's rx_addr bit is valid this cycle.
- rx_addr, input, 1: serial address bit from the owning master.
- tx_done, input, 1: one-cycle pulse from the selected slave at transaction end.
- split_req, input, 1: selected slave requests a split.
- split_done, input, 1: split slave is ready to resume (level, held until resumed).
- slave_sel, output, SEL_BITS: selected slave index.
- sel_valid, output, 1: slave_sel is valid and the slave is connected.
- bus_busy, output, 1: high in any state other than IDLE.
- addr_err, output, 1: one-cycle pulse when the decoded index is >= NUM_SLAVES.
- timeout_err, output, 1: one-cycle pulse on timeout abort.

Behaviour:
- Reset: every output is 0. State goes to IDLE, last_winner=2 (so m1 wins the first tie), split_pending=0, and all counters clear.
- Outputs are registered. A request seen in IDLE at cycle n produces a grant at n+1.
- IDLE:
  - If split_pending and split_done: re-grant split_owner, restore the saved slave_sel, and go to CONNECT. This takes priority over new requests.
  - Else if exactly one of m1_req/m2_req is high: grant it.
  - Else if both are high: grant the master that is not last_winner.
  - On any grant, go to GRANT and update last_winner.
  - A master already parked in a split is not granted again until resumed.
- GRANT: enters ADDR the next cycle. If the owner's req has dropped, release the grant and go to IDLE.
- ADDR:
  - On each master_valid=1 cycle, shift rx_addr into sel_shift (MSB first) and increment bit_cnt.
  - After SEL_BITS bits: if the index is < NUM_SLAVES, set slave_sel and sel_valid=1 and go to CONNECT. Otherwise pulse addr_err, drop the grant, and go to IDLE.
  - Owner req dropping here aborts to IDLE, with no error pulse.
  - The remaining address bits pass through untouched.
- CONNECT:
  - The timeout counter increments each cycle and is cleared on entry.
  - tx_done: drop grant and sel_valid, go to IDLE.
  - split_req (without tx_done): record split_owner and saved_sel, set split_pending, drop grant and sel_valid, go to IDLE. The other master may then use the bus.
  - counter == TIMEOUT: pulse timeout_err, drop everything, go to IDLE. A pending split for the same owner is cleared.
  - Simultaneous tx_done and split_req: tx_done wins.
  - Simultaneous tx_done and counter==TIMEOUT: tx_done wins, no error.
- Only one split may be pending. A split_req while split_pending is treated as tx_done (transaction closed) and does not overwrite the pending split.
- The grants are mutually exclusive at all times. sel_valid implies exactly one grant.
- Reset mid-operation (any state) returns to the reset values on the next edge. Any pending split is discarded.
- Widths: bit_cnt is clog2(SEL_BITS+1) bits; the timeout counter is clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package bus_pkg: state enum (IDLE, GRANT, ADDR, CONNECT), master IDs (M1=1, M2=2), SEL_BITS/NUM_SLAVES defaults, and the 12-bit local address width constant shared with the slave ports.
- One natural sub-module: rr_arbiter_2, the combinational two-request round-robin pick from last_winner.
- The FSM, shifter and counters stay in bus_arbiter.

Test Plan:
- m1_req=1 alone, shift bits 1,0 with master_valid → m1_grant at cycle+1; slave_sel=2, sel_valid=1 two valid-cycles after GRANT; tx_done → all outputs 0 next cycle.
- m1_req and m2_req both high from reset, each completing with tx_done → grant order m1, m2, m1, m2.
- m2 owns, shifts 1,1 → addr_err pulses for one cycle, m2_grant drops, state IDLE, sel_valid never asserted.
- m1 connected to slave 1, split_req=1 while m2_req=1 → m1_grant drops and m2 is granted next cycle. m2 completes; split_done=1 → m1_grant=1, slave_sel=1, sel_valid=1 with no address phase.
- Connected with no tx_done for 255 cycles → timeout_err pulse on cycle 255 of CONNECT, grants drop. tx_done on that same cycle → no timeout_err.
- reset=1 during CONNECT with a split pending → the next cycle shows all outputs 0; a later split_done is ignored.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the serial system bus
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      ADDR    = 2'd2,
      CONNECT = 2'd3
   } state_t;

   typedef logic [1:0] master_id_t;

   localparam master_id_t M_NONE = 2'd0;
   localparam master_id_t M1     = 2'd1;
   localparam master_id_t M2     = 2'd2;

   localparam int SEL_BITS_DEF   = 2;
   localparam int NUM_SLAVES_DEF = 3;
   localparam int TIMEOUT_DEF    = 255;
   // Local address width behind each slave port (4K x 8 BRAM)
   localparam int LOCAL_ADDR_W   = 12;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant, serial address and completion signals of the bus
interface bus_arbiter_if #(
   parameter int SEL_BITS = bus_pkg::SEL_BITS_DEF
);
   logic                m1_req;
   logic                m2_req;
   logic                m1_grant;
   logic                m2_grant;
   logic                master_valid;
   logic                rx_addr;
   logic                tx_done;
   logic                split_req;
   logic                split_done;
   logic [SEL_BITS-1:0] slave_sel;
   logic                sel_valid;
   logic                bus_busy;
   logic                addr_err;
   logic                timeout_err;

   // master: the requesters and slaves driving the arbiter
   modport master (
      output m1_req, m2_req, master_valid, rx_addr, tx_done, split_req, split_done,
      input  m1_grant, m2_grant, slave_sel, sel_valid, bus_busy, addr_err, timeout_err
   );

   // slave: the arbiter itself
   modport slave (
      input  m1_req, m2_req, master_valid, rx_addr, tx_done, split_req, split_done,
      output m1_grant, m2_grant, slave_sel, sel_valid, bus_busy, addr_err, timeout_err
   );
endinterface

// File: rtl/bus_arbiter_rr_arbiter_2.sv
// rtl/bus_arbiter_rr_arbiter_2.sv - two-request round-robin pick keyed on the last winner
module rr_arbiter_2
   import bus_pkg::*;
(
   input  logic       req1,
   input  logic       req2,
   input  master_id_t last_winner,
   output master_id_t pick
);

   always_comb begin
      pick = M_NONE;
      if (req1 && req2) begin
         pick = (last_winner == M1) ? M2 : M1;
      end else if (req1) begin
         pick = M1;
      end else if (req2) begin
         pick = M2;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with serial slave select, split and timeout
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_SLAVES = NUM_SLAVES_DEF,
   parameter int SEL_BITS   = SEL_BITS_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          reset,
   bus_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(SEL_BITS + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SEL_BITS - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
   localparam logic [SEL_BITS:0] SEL_LIM  = (SEL_BITS + 1)'(NUM_SLAVES);

   state_t              state_q, state_d;
   logic                g1_q, g1_d;
   logic                g2_q, g2_d;
   logic [SEL_BITS-1:0] sel_q, sel_d;
   logic                sel_valid_q, sel_valid_d;
   logic                busy_q;
   logic                addr_err_q, addr_err_d;
   logic                to_err_q, to_err_d;
   master_id_t          last_winner_q, last_winner_d;
   logic                split_pending_q, split_pending_d;
   master_id_t          split_owner_q, split_owner_d;
   logic [SEL_BITS-1:0] saved_sel_q, saved_sel_d;
   logic [SEL_BITS-1:0] sel_shift_q, sel_shift_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

   master_id_t          owner;
   logic                owner_req;
   logic                elig1, elig2;
   master_id_t          pick;
   logic [SEL_BITS-1:0] shifted;
   logic [TO_W-1:0]     elapsed;

   assign owner     = g1_q ? M1 : (g2_q ? M2 : M_NONE);
   assign owner_req = (g1_q && bus.m1_req) || (g2_q && bus.m2_req);
   assign shifted   = (sel_shift_q << 1) | SEL_BITS'(bus.rx_addr);
   // elapsed includes the current CONNECT cycle
   assign elapsed   = (to_cnt_q == TO_MAX) ? TO_MAX : to_cnt_q + 1'b1;

   // A master parked in a split stays out of arbitration until resumed
   assign elig1 = bus.m1_req && !(split_pending_q && split_owner_q == M1);
   assign elig2 = bus.m2_req && !(split_pending_q && split_owner_q == M2);

   rr_arbiter_2 u_rr (
      .req1        (elig1),
      .req2        (elig2),
      .last_winner (last_winner_q),
      .pick        (pick)
   );

   always_comb begin
      state_d         = state_q;
      g1_d            = g1_q;
      g2_d            = g2_q;
      sel_d           = sel_q;
      sel_valid_d     = sel_valid_q;
      addr_err_d      = 1'b0;
      to_err_d        = 1'b0;
      last_winner_d   = last_winner_q;
      split_pending_d = split_pending_q;
      split_owner_d   = split_owner_q;
      saved_sel_d     = saved_sel_q;
      sel_shift_d     = sel_shift_q;
      bit_cnt_d       = bit_cnt_q;
      to_cnt_d        = to_cnt_q;

      case (state_q)
         IDLE: begin
            sel_shift_d = '0;
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            if (split_pending_q && bus.split_done) begin
               g1_d            = (split_owner_q == M1);
               g2_d            = (split_owner_q == M2);
               sel_d           = saved_sel_q;
               sel_valid_d     = 1'b1;
               split_pending_d = 1'b0;
               state_d         = CONNECT;
            end else if (pick != M_NONE) begin
               g1_d          = (pick == M1);
               g2_d          = (pick == M2);
               last_winner_d = pick;
               state_d       = GRANT;
            end
         end

         GRANT: begin
            if (!owner_req) begin
               g1_d    = 1'b0;
               g2_d    = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = ADDR;
            end
         end

         ADDR: begin
            if (!owner_req) begin
               g1_d    = 1'b0;
               g2_d    = 1'b0;
               state_d = IDLE;
            end else if (bus.master_valid) begin
               sel_shift_d = shifted;
               bit_cnt_d   = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  if ({1'b0, shifted} < SEL_LIM) begin
                     sel_d       = shifted;
                     sel_valid_d = 1'b1;
                     state_d     = CONNECT;
                  end else begin
                     addr_err_d = 1'b1;
                     g1_d       = 1'b0;
                     g2_d       = 1'b0;
                     state_d    = IDLE;
                  end
               end
            end
         end

         CONNECT: begin
            to_cnt_d = elapsed;
            if (bus.tx_done || bus.split_req || elapsed == TO_MAX) begin
               g1_d        = 1'b0;
               g2_d        = 1'b0;
               sel_d       = '0;
               sel_valid_d = 1'b0;
               state_d     = IDLE;
            end
            // Second split while one is parked just closes the transaction
            if (!bus.tx_done && bus.split_req && !split_pending_q) begin
               split_pending_d = 1'b1;
               split_owner_d   = owner;
               saved_sel_d     = sel_q;
            end else if (!bus.tx_done && !bus.split_req && elapsed == TO_MAX) begin
               to_err_d = 1'b1;
               if (split_pending_q && split_owner_q == owner) begin
                  split_pending_d = 1'b0;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         g1_q            <= 1'b0;
         g2_q            <= 1'b0;
         sel_q           <= '0;
         sel_valid_q     <= 1'b0;
         busy_q          <= 1'b0;
         addr_err_q      <= 1'b0;
         to_err_q        <= 1'b0;
         last_winner_q   <= M2;
         split_pending_q <= 1'b0;
         split_owner_q   <= M_NONE;
         saved_sel_q     <= '0;
         sel_shift_q     <= '0;
         bit_cnt_q       <= '0;
         to_cnt_q        <= '0;
      end else begin
         state_q         <= state_d;
         g1_q            <= g1_d;
         g2_q            <= g2_d;
         sel_q           <= sel_d;
         sel_valid_q     <= sel_valid_d;
         busy_q          <= (state_d != IDLE);
         addr_err_q      <= addr_err_d;
         to_err_q        <= to_err_d;
         last_winner_q   <= last_winner_d;
         split_pending_q <= split_pending_d;
         split_owner_q   <= split_owner_d;
         saved_sel_q     <= saved_sel_d;
         sel_shift_q     <= sel_shift_d;
         bit_cnt_q       <= bit_cnt_d;
         to_cnt_q        <= to_cnt_d;
      end
   end

   assign bus.m1_grant    = g1_q;
   assign bus.m2_grant    = g2_q;
   assign bus.slave_sel   = sel_q;
   assign bus.sel_valid   = sel_valid_q;
   assign bus.bus_busy    = busy_q;
   assign bus.addr_err    = addr_err_q;
   assign bus.timeout_err = to_err_q;

endmodule
